// File: rtl/edge_pulser_pkg.sv
// edge_pulser shared definitions.
// Edge-select encodings, channel states and counter sizing.
package edge_pulser_pkg;

    localparam logic [1:0] EP_RISE = 2'b00;
    localparam logic [1:0] EP_FALL = 2'b01;
    localparam logic [1:0] EP_BOTH = 2'b10;
    localparam logic [1:0] EP_NONE = 2'b11;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } chan_state_e;

    // Bits needed to hold a count of 0..pulse_len.
    function automatic int cnt_w(input int pulse_len);
        return $clog2(pulse_len + 1);
    endfunction

endpackage

// File: rtl/edge_pulser_chan.sv
// edge_pulser single channel.
// Edge detect, qualify, and pulse-width counter.
module edge_pulser_chan
    import edge_pulser_pkg::*;
#(
    parameter int PULSE_LEN = 2,
    parameter int RETRIG    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       armed,
    input  logic       lvl,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       pulse_d,
    output logic       pulse
);

    localparam int CW = cnt_w(PULSE_LEN);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);
    localparam logic [CW-1:0] ONE  = CW'(1);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic          out_q, out_d;
    logic          rise, fall, sel, hit;

    // Select the requested edge type and qualify it.
    always_comb begin
        rise = lvl & ~prev_q;
        fall = ~lvl & prev_q;
        sel  = 1'b0;
        unique case (mode)
            EP_RISE: sel = rise;
            EP_FALL: sel = fall;
            EP_BOTH: sel = rise | fall;
            default: sel = 1'b0;
        endcase
        hit    = armed & en & sel;
        prev_d = lvl;
    end

    // Next state: load on an edge, count down while active.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CH_IDLE: begin
                if (hit) begin
                    cnt_d   = LOAD;
                    state_d = CH_ACTIVE;
                end
            end
            CH_ACTIVE: begin
                if (hit && (RETRIG != 0)) begin
                    cnt_d = LOAD;
                end else begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = CH_IDLE;
                    end
                end
            end
        endcase
        out_d = (state_d == CH_ACTIVE);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            out_q   <= out_d;
        end
    end

    assign pulse_d = out_d;
    assign pulse   = out_q;

endmodule

// File: rtl/edge_pulser.sv
// edge_pulser top level.
// Per-channel pulse generators plus shared arm flag and OR output.
module edge_pulser
    import edge_pulser_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 2,
    parameter int RETRIG    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] en,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] out,
    output logic                any
);

    if (PULSE_LEN < 1) begin : g_bad_len
        $error("edge_pulser: PULSE_LEN must be >= 1");
    end

    if (CHANNELS < 1) begin : g_bad_ch
        $error("edge_pulser: CHANNELS must be >= 1");
    end

    logic                armed_q, armed_d;
    logic                any_q, any_d;
    logic [CHANNELS-1:0] out_nxt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_pulser_chan #(
            .PULSE_LEN (PULSE_LEN),
            .RETRIG    (RETRIG)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .armed   (armed_q),
            .lvl     (in[i]),
            .en      (en[i]),
            .mode    (mode),
            .pulse_d (out_nxt[i]),
            .pulse   (out[i])
        );
    end

    // First edge after reset only captures inputs; detection starts after.
    always_comb begin
        armed_d = 1'b1;
        any_d   = |out_nxt;
    end

    // Shared registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            any_q   <= any_d;
        end
    end

    assign any = any_q;

endmodule

// File: doc/edge_pulser.md
# edge_pulser

Multi-channel, synchronous successor to the single-channel edge gate. Each channel samples a level input on `clk`, detects a selected edge type, and emits a clean output pulse of a parametrised number of clock cycles. Sits between slow control signals (buttons, strobes, enable lines) and sequential logic that needs exactly one bounded pulse per event.

## Interface

Parameters:
- `CHANNELS`, 4, number of independent channels (>= 1)
- `PULSE_LEN`, 2, output pulse width in `clk` cycles (>= 1; 0 is a compile-time error)
- `RETRIG`, 1, 1 = an edge during an active pulse restarts the full width; 0 = such edges are ignored

Ports:
- `clk`  input  1  single clock; all state changes on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in`  input  CHANNELS  level inputs, one per channel, synchronous to `clk`
- `en`  input  CHANNELS  per-channel detection enable
- `mode`  input  2  edge select, shared by all channels: 00 rising, 01 falling, 10 both, 11 none
- `out`  output  CHANNELS  per-channel pulse outputs, registered
- `any`  output  1  registered OR of all `out` bits

## Operation

- Per-channel state: `prev` (last sampled `in`), `cnt` (remaining pulse cycles, width clog2(PULSE_LEN+1)). Shared state: `armed` flag.
- Reset (`rst_n` low, asynchronous): `prev`=0, `cnt`=0, `armed`=0, `out`=0, `any`=0. Effect is immediate, mid-pulse or not.
- First rising edge after reset release: `prev` loads `in`, `armed` sets, no detection. A channel that is high at reset release does not fire.
- Edge condition at a clock edge when `armed`: rise = `in` & ~`prev`; fall = ~`in` & `prev`; selected by `mode`; qualified by `en[i]`.
- Per-channel state machine, two states:
  - IDLE (`cnt`=0): qualified edge -> ACTIVE, `cnt`=PULSE_LEN.
  - ACTIVE (`cnt`>0): `cnt` decrements each cycle; reaching 0 -> IDLE. Qualified edge with RETRIG=1 -> `cnt` reloads to PULSE_LEN (no decrement that cycle). With RETRIG=0 the edge is dropped.
- `out[i]` = (`cnt[i]` != 0), registered (driven from next-state so it is high in the same cycle `cnt` loads).
- `prev` updates every cycle regardless of `en`, `mode`, or state.
- Deasserting `en[i]` or setting `mode`=11 mid-pulse does not truncate the pulse; it only blocks new detections.
- `mode` changes take effect at the next clock edge; no edge is synthesised from a mode change.

## Timing

- Input transition between edges N-1 and N -> detected at edge N -> `out` high from edge N for exactly PULSE_LEN cycles, low after edge N+PULSE_LEN.
- Detection latency: 1 edge. No combinational path from any input to `out` or `any`.
- `any` follows the same timing as `out` (computed from next-state, registered).
- mode 10 with a 1-cycle glitch on `in` (rise at N, fall at N+1): RETRIG=1 -> pulse from N to N+1+PULSE_LEN; RETRIG=0 -> single pulse of PULSE_LEN.
- PULSE_LEN=1 with back-to-back edges every cycle and RETRIG=1: `out` stays high continuously.
- `in` is not synchronised internally; asynchronous sources require an external synchroniser.

## Structure

- Package `edge_pulser_pkg`: mode constants (`EP_RISE`, `EP_FALL`, `EP_BOTH`, `EP_NONE`) and the counter-width function.
- Sub-module `edge_pulser_chan`: one channel (`prev`, `cnt`, edge qualify, `out`), parametrised by PULSE_LEN and RETRIG; instantiated CHANNELS times in a generate loop. Top level holds `armed` and `any`.

## Test plan

- Reset with `in`=4'b1111, release, hold for 10 cycles -> `out`=0, `any`=0 throughout (no spurious fire).
- PULSE_LEN=2, mode=00, en=4'b0001, raise `in[0]` before edge N -> `out[0]` high for edges N, N+1, low at N+2; `out[3:1]`=0; falling edge later -> no pulse.
- mode=10, RETRIG=1, PULSE_LEN=3, `in[1]` rises before N, falls before N+2 -> `out[1]` high N..N+4 (5 cycles); repeat with RETRIG=0 -> high N..N+2 only.
- Pulse active on channel 2, deassert `en[2]` and set mode=11 at N+1 -> pulse still completes its full PULSE_LEN; subsequent edges ignored.
- Assert `rst_n` low asynchronously mid-pulse (between edges) -> `out`, `any` drop to 0 immediately; after release, first edge does not fire.
- Simultaneous rising edges on all 4 channels with en=4'b1010 -> `out`=4'b1010 for PULSE_LEN cycles, `any`=1 over the same window.
